frame_priority_collector: RTL and testbench
===========================================

// Module: frame_priority_collector
// PURPOSE
//  Output-port sink of the crossbar: the receive end of the frame_priority_delivers transfer.
//  - Accepts one granted frame at a time (source port, priority, arrival timestamp).
//  - Holds the output busy for one frame time, then pulses completion.
//  - Keeps per-priority latency statistics: count, min, max, total.
//  - One instance per output port; o_busy feeds the scheduler's output-idle vector (inverted).
// PARAMETERS
//  PORT         8    number of input ports; width of one-hot source field
//  PRIORITY     4    number of priority classes; width of one-hot priority field
//  WIDTH        32   timestamp / counter width
//  PRI_BITS     2    log2(PRIORITY); width of statistics select
//  PERIOD       8    clock period in ns
//  FRAME_BYTES  64   frame length in bytes
//  SPEED        10   ns per bit (10 = 100 Mb/s, 1 = 1 Gb/s)
//  localparam HOLD = (FRAME_BYTES*8*SPEED + PERIOD-1)/PERIOD  (640 cycles at defaults)
// PORTS
//  clk          in   1                    clock, all logic on rising edge
//  reset        in   1                    synchronous, active-high
//  i_valid      in   1                    frame offered this cycle
//  i_src_port   in   PORT                 one-hot source input port
//  i_pri        in   PRIORITY             one-hot priority class
//  i_data       in   WIDTH                arrival timestamp carried by frame
//  i_now        in   WIDTH                current time, same units as i_data
//  i_stat_sel   in   PRI_BITS             priority index for statistics read
//  o_busy       out  1                    frame in progress
//  o_done       out  1                    1-cycle pulse at end of frame
//  o_err        out  1                    1-cycle pulse: malformed frame dropped
//  o_last_src   out  PORT                 one-hot source of last accepted frame
//  o_collisions out  WIDTH                frames offered while busy
//  o_cnt        out  WIDTH                frames received, class i_stat_sel
//  o_min_delay  out  WIDTH                min delay, class i_stat_sel
//  o_max_delay  out  WIDTH                max delay, class i_stat_sel
//  o_tot_delay  out  2*WIDTH              summed delay, class i_stat_sel
// BEHAVIOUR
//  - Reset: state IDLE; o_busy/o_done/o_err = 0; o_last_src = 0; o_collisions = 0.
//    Per class: cnt = 0, max = 0, tot = 0, min = all ones. Reset mid-frame aborts the frame.
//  - FSM:
//    - IDLE: on i_valid with exactly one bit set in i_src_port and exactly one in i_pri:
//      - latch the frame; hold counter = HOLD-1; enter RECV; o_busy = 1 from the next cycle.
//      - If either field is zero or multi-hot: o_err = 1 next cycle, frame dropped, stay IDLE.
//    - RECV: counter decrements each cycle. At 0: go to IDLE, o_busy = 0, o_done = 1 for that cycle.
//      Frame occupies exactly HOLD cycles of o_busy.
//    - i_valid in RECV: discard the frame, o_collisions += 1 (saturate at all ones).
//      The current frame is unaffected.
//    - i_valid on the cycle RECV ends (counter = 0): counts as a collision. A new frame is
//      accepted no earlier than the first cycle with o_busy = 0.
//  - Delay = i_now - i_data, WIDTH-bit modulo subtraction, so timestamp wrap yields the
//    correct small delay.
//  - Statistics update on the acceptance edge, class = index of the i_pri bit:
//    - cnt += 1, saturating.
//    - tot += zero-extended delay, 2*WIDTH wide, wraps.
//    - min = delay if smaller; max = delay if larger.
//    - Equal values: no change.
//  - Statistics read is combinational from i_stat_sel. Out-of-range select returns zeros.
//  - o_last_src updates at acceptance and holds until the next accepted frame.
// TESTING
//  - Reset, idle: o_busy = 0; for every class o_cnt = 0 and o_min_delay = FFFF_FFFF.
//  - i_valid, src = 8'h04, pri = 4'h2, i_data = 100, i_now = 180 ->
//    o_busy high for 640 cycles, o_done once; class 1: cnt = 1, min = max = tot = 80;
//    o_last_src = 8'h04.
//  - Second frame, pri = 4'h2, delay 20, offered 3 cycles after o_done ->
//    class 1: cnt = 2, min = 20, max = 80, tot = 100.
//  - Offer 3 frames while busy -> o_collisions = 3; busy length still 640; stats unchanged.
//  - src = 8'h06 (multi-hot) or pri = 0 -> o_err pulses 1 cycle; o_busy stays 0; counts unchanged.
//  - Wrap: i_data = FFFF_FFF0, i_now = 0000_0010 -> delay recorded as 32.
//    Then assert reset mid-RECV -> next cycle o_busy = 0 and all statistics at reset values.

Source files
------------

// File: rtl/frame_priority_collector.sv
// rtl/frame_priority_collector.sv - output-port frame sink with per-priority latency statistics
module frame_priority_collector #(
    parameter int PORT        = 8,
    parameter int PRIORITY    = 4,
    parameter int WIDTH       = 32,
    parameter int PRI_BITS    = 2,
    parameter int PERIOD      = 8,
    parameter int FRAME_BYTES = 64,
    parameter int SPEED       = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [PORT-1:0]       i_src_port,
    input  logic [PRIORITY-1:0]   i_pri,
    input  logic [WIDTH-1:0]      i_data,
    input  logic [WIDTH-1:0]      i_now,
    input  logic [PRI_BITS-1:0]   i_stat_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [PORT-1:0]       o_last_src,
    output logic [WIDTH-1:0]      o_collisions,
    output logic [WIDTH-1:0]      o_cnt,
    output logic [WIDTH-1:0]      o_min_delay,
    output logic [WIDTH-1:0]      o_max_delay,
    output logic [2*WIDTH-1:0]    o_tot_delay
);

    // Frame time in clock cycles, rounded up so the wire is never released early.
    localparam int HOLD = (FRAME_BYTES * 8 * SPEED + PERIOD - 1) / PERIOD;
    localparam int CW   = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         hold_q, hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [PORT-1:0]       last_src_q, last_src_d;
    logic [WIDTH-1:0]      coll_q, coll_d;

    logic [WIDTH-1:0]      cnt_q [PRIORITY];
    logic [WIDTH-1:0]      cnt_d [PRIORITY];
    logic [WIDTH-1:0]      min_q [PRIORITY];
    logic [WIDTH-1:0]      min_d [PRIORITY];
    logic [WIDTH-1:0]      max_q [PRIORITY];
    logic [WIDTH-1:0]      max_d [PRIORITY];
    logic [2*WIDTH-1:0]    tot_q [PRIORITY];
    logic [2*WIDTH-1:0]    tot_d [PRIORITY];

    logic                  frame_ok;
    logic                  accept;
    logic [PRI_BITS-1:0]   pri_idx;
    logic [WIDTH-1:0]      delay;

    assign frame_ok = $onehot(i_src_port) && $onehot(i_pri);
    assign accept   = (state_q == IDLE) && i_valid && frame_ok;
    // Modulo subtraction keeps the delay correct across a timestamp wrap.
    assign delay    = i_now - i_data;

    // Convert the one-hot priority into a statistics index.
    always_comb begin
        pri_idx = '0;
        for (int i = 0; i < PRIORITY; i++) begin
            if (i_pri[i]) begin
                pri_idx = PRI_BITS'(i);
            end
        end
    end

    // Receive FSM: accept or reject in IDLE, count down one frame time in RECV.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        last_src_d = last_src_q;
        coll_d     = coll_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (frame_ok) begin
                        state_d    = RECV;
                        hold_d     = CW'(HOLD - 1);
                        busy_d     = 1'b1;
                        last_src_d = i_src_port;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                // Anything offered while the wire is occupied is dropped, including the final cycle.
                if (i_valid && (coll_q != '1)) begin
                    coll_d = coll_q + 1'b1;
                end
                if (hold_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Latency statistics for the accepted frame's class.
    always_comb begin
        cnt_d = cnt_q;
        min_d = min_q;
        max_d = max_q;
        tot_d = tot_q;
        if (accept) begin
            if (cnt_q[pri_idx] != '1) begin
                cnt_d[pri_idx] = cnt_q[pri_idx] + 1'b1;
            end
            tot_d[pri_idx] = tot_q[pri_idx] + {{WIDTH{1'b0}}, delay};
            if (delay < min_q[pri_idx]) begin
                min_d[pri_idx] = delay;
            end
            if (delay > max_q[pri_idx]) begin
                max_d[pri_idx] = delay;
            end
        end
    end

    // State and statistics registers; reset also aborts a frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            last_src_q <= '0;
            coll_q     <= '0;
            for (int i = 0; i < PRIORITY; i++) begin
                cnt_q[i] <= '0;
                min_q[i] <= '1;
                max_q[i] <= '0;
                tot_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            last_src_q <= last_src_d;
            coll_q     <= coll_d;
            cnt_q      <= cnt_d;
            min_q      <= min_d;
            max_q      <= max_d;
            tot_q      <= tot_d;
        end
    end

    // Combinational statistics read; a select beyond the class count reads as zero.
    always_comb begin
        o_cnt       = '0;
        o_min_delay = '0;
        o_max_delay = '0;
        o_tot_delay = '0;
        if (32'(i_stat_sel) < 32'(PRIORITY)) begin
            o_cnt       = cnt_q[i_stat_sel];
            o_min_delay = min_q[i_stat_sel];
            o_max_delay = max_q[i_stat_sel];
            o_tot_delay = tot_q[i_stat_sel];
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_last_src   = last_src_q;
    assign o_collisions = coll_q;

endmodule

// File: tb/tb_frame_priority_collector.sv
// tb/tb_frame_priority_collector.sv - self-checking bench for frame_priority_collector
module tb_frame_priority_collector;

    localparam int HOLD = 640;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [7:0]  i_src_port;
    logic [3:0]  i_pri;
    logic [31:0] i_data;
    logic [31:0] i_now;
    logic [1:0]  i_stat_sel;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [7:0]  o_last_src;
    logic [31:0] o_collisions;
    logic [31:0] o_cnt;
    logic [31:0] o_min_delay;
    logic [31:0] o_max_delay;
    logic [63:0] o_tot_delay;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] m_cnt [4];
    logic [31:0] m_min [4];
    logic [31:0] m_max [4];
    logic [63:0] m_tot [4];
    logic [31:0] m_coll;
    logic [7:0]  m_last;

    frame_priority_collector dut (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .i_src_port   (i_src_port),
        .i_pri        (i_pri),
        .i_data       (i_data),
        .i_now        (i_now),
        .i_stat_sel   (i_stat_sel),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_last_src   (o_last_src),
        .o_collisions (o_collisions),
        .o_cnt        (o_cnt),
        .o_min_delay  (o_min_delay),
        .o_max_delay  (o_max_delay),
        .o_tot_delay  (o_tot_delay)
    );

    always #4 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0;
            m_min[c] = 32'hFFFF_FFFF;
            m_max[c] = 0;
            m_tot[c] = 0;
        end
        m_coll = 0;
        m_last = 0;
    endtask

    task automatic model_accept(input logic [7:0] src, input logic [3:0] pri,
                                input logic [31:0] data, input logic [31:0] now);
        int c;
        logic [31:0] d;
        c = 0;
        for (int i = 0; i < 4; i++) if (pri[i]) c = i;
        d = now - data;
        m_cnt[c] = m_cnt[c] + 1;
        m_tot[c] = m_tot[c] + 64'(d);
        if (d < m_min[c]) m_min[c] = d;
        if (d > m_max[c]) m_max[c] = d;
        m_last = src;
    endtask

    task automatic offer(input logic [7:0] src, input logic [3:0] pri,
                         input logic [31:0] data, input logic [31:0] now);
        i_valid    = 1'b1;
        i_src_port = src;
        i_pri      = pri;
        i_data     = data;
        i_now      = now;
        tick();
        i_valid    = 1'b0;
    endtask

    // Walks through the busy window, optionally offering random frames; leaves the bench on the first idle cycle.
    task automatic run_busy(input int rate, output int len, output int offers, output int early);
        len = 0; offers = 0; early = 0;
        while (o_busy === 1'b1 && len < 2000) begin
            len++;
            if (o_done !== 1'b0) early++;
            if (rate > 0 && $urandom_range(0, rate - 1) == 0) begin
                i_valid    = 1'b1;
                i_src_port = 8'($urandom);
                i_pri      = 4'($urandom);
                i_data     = $urandom;
                i_now      = $urandom;
                offers++;
            end
            tick();
            i_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; i_valid = 1'b0; i_src_port = 0; i_pri = 0;
        i_data = 0; i_now = 0; i_stat_sel = 0;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        total_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else pass_cnt++;
        total_cnt++; if (o_done !== 1'b0 || o_err !== 1'b0) $display("FAIL reset_pulses: done %b err %b want 0 0", o_done, o_err); else pass_cnt++;
        total_cnt++; if (o_last_src !== 8'h00 || o_collisions !== 32'h0) $display("FAIL reset_src_coll: src %h coll %0d want 00 0", o_last_src, o_collisions); else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            i_stat_sel = 2'(c); #1;
            total_cnt++;
            if (o_cnt !== 32'h0 || o_min_delay !== 32'hFFFF_FFFF || o_max_delay !== 32'h0 || o_tot_delay !== 64'h0)
                $display("FAIL reset_stats[%0d]: cnt %0d min %h max %0d tot %0d want 0 ffffffff 0 0", c, o_cnt, o_min_delay, o_max_delay, o_tot_delay);
            else pass_cnt++;
        end
    endtask

    task automatic test_first_frame();
        int len, offs, early;
        offer(8'h04, 4'h2, 32'd100, 32'd180);
        model_accept(8'h04, 4'h2, 32'd100, 32'd180);
        total_cnt++; if (o_busy !== 1'b1) $display("FAIL first_busy_start: got %b want 1", o_busy); else pass_cnt++;
        total_cnt++; if (o_last_src !== 8'h04) $display("FAIL first_last_src: got %h want 04", o_last_src); else pass_cnt++;
        run_busy(0, len, offs, early);
        total_cnt++; if (len != HOLD) $display("FAIL first_busy_len: got %0d want %0d", len, HOLD); else pass_cnt++;
        total_cnt++; if (early != 0 || o_done !== 1'b1) $display("FAIL first_done: early %0d done %b want 0 1", early, o_done); else pass_cnt++;
        tick();
        total_cnt++; if (o_done !== 1'b0) $display("FAIL first_done_pulse: got %b want 0", o_done); else pass_cnt++;
        i_stat_sel = 2'd1; #1;
        total_cnt++;
        if (o_cnt !== 32'd1 || o_min_delay !== 32'd80 || o_max_delay !== 32'd80 || o_tot_delay !== 64'd80)
            $display("FAIL first_stats: cnt %0d min %0d max %0d tot %0d want 1 80 80 80", o_cnt, o_min_delay, o_max_delay, o_tot_delay);
        else pass_cnt++;
    endtask

    task automatic test_second_frame();
        int len, offs, early;
        tick(); tick();
        offer(8'h20, 4'h2, 32'd500, 32'd520);
        model_accept(8'h20, 4'h2, 32'd500, 32'd520);
        run_busy(0, len, offs, early);
        total_cnt++; if (len != HOLD) $display("FAIL second_busy_len: got %0d want %0d", len, HOLD); else pass_cnt++;
        tick();
        i_stat_sel = 2'd1; #1;
        total_cnt++;
        if (o_cnt !== 32'd2 || o_min_delay !== 32'd20 || o_max_delay !== 32'd80 || o_tot_delay !== 64'd100)
            $display("FAIL second_stats: cnt %0d min %0d max %0d tot %0d want 2 20 80 100", o_cnt, o_min_delay, o_max_delay, o_tot_delay);
        else pass_cnt++;
    endtask

    task automatic test_collisions();
        int n;
        int early;
        offer(8'h01, 4'h8, 32'd1000, 32'd1005);
        model_accept(8'h01, 4'h8, 32'd1000, 32'd1005);
        n = 0; early = 0;
        while (o_busy === 1'b1 && n < 2000) begin
            n++;
            if (o_done !== 1'b0) early++;
            // The last offer lands on the final busy cycle and must still be refused.
            if (n == 10 || n == 300 || n == HOLD) begin
                i_valid = 1'b1; i_src_port = 8'h80; i_pri = 4'h2; i_data = 0; i_now = 32'd1;
                m_coll = m_coll + 1;
            end
            tick();
            i_valid = 1'b0;
        end
        total_cnt++; if (n != HOLD) $display("FAIL coll_busy_len: got %0d want %0d", n, HOLD); else pass_cnt++;
        total_cnt++; if (o_collisions !== 32'd3) $display("FAIL coll_count: got %0d want 3", o_collisions); else pass_cnt++;
        total_cnt++; if (early != 0 || o_done !== 1'b1) $display("FAIL coll_done: early %0d done %b want 0 1", early, o_done); else pass_cnt++;
        tick();
        total_cnt++; if (o_busy !== 1'b0 || o_last_src !== 8'h01) $display("FAIL coll_after: busy %b src %h want 0 01", o_busy, o_last_src); else pass_cnt++;
        i_stat_sel = 2'd1; #1;
        total_cnt++;
        if (o_cnt !== 32'd2 || o_min_delay !== 32'd20 || o_max_delay !== 32'd80 || o_tot_delay !== 64'd100)
            $display("FAIL coll_stats1: cnt %0d min %0d max %0d tot %0d want 2 20 80 100", o_cnt, o_min_delay, o_max_delay, o_tot_delay);
        else pass_cnt++;
        i_stat_sel = 2'd3; #1;
        total_cnt++;
        if (o_cnt !== 32'd1 || o_min_delay !== 32'd5 || o_max_delay !== 32'd5 || o_tot_delay !== 64'd5)
            $display("FAIL coll_stats3: cnt %0d min %0d max %0d tot %0d want 1 5 5 5", o_cnt, o_min_delay, o_max_delay, o_tot_delay);
        else pass_cnt++;
    endtask

    task automatic test_malformed();
        logic [7:0] srcs [4];
        logic [3:0] pris [4];
        srcs = '{8'h06, 8'h04, 8'h00, 8'h04};
        pris = '{4'h2,  4'h0,  4'h1,  4'h3};
        for (int k = 0; k < 4; k++) begin
            offer(srcs[k], pris[k], 32'd0, 32'd7);
            total_cnt++; if (o_err !== 1'b1 || o_busy !== 1'b0) $display("FAIL malformed_err[%0d]: err %b busy %b want 1 0", k, o_err, o_busy); else pass_cnt++;
            tick();
            total_cnt++; if (o_err !== 1'b0 || o_busy !== 1'b0) $display("FAIL malformed_pulse[%0d]: err %b busy %b want 0 0", k, o_err, o_busy); else pass_cnt++;
        end
        i_stat_sel = 2'd1; #1;
        total_cnt++; if (o_cnt !== 32'd2 || o_last_src !== 8'h01 || o_collisions !== 32'd3)
            $display("FAIL malformed_unchanged: cnt %0d src %h coll %0d want 2 01 3", o_cnt, o_last_src, o_collisions);
        else pass_cnt++;
    endtask

    task automatic test_wrap_reset();
        offer(8'h10, 4'h1, 32'hFFFF_FFF0, 32'h0000_0010);
        i_stat_sel = 2'd0; #1;
        total_cnt++;
        if (o_cnt !== 32'd1 || o_min_delay !== 32'd32 || o_max_delay !== 32'd32 || o_tot_delay !== 64'd32)
            $display("FAIL wrap_stats: cnt %0d min %0d max %0d tot %0d want 1 32 32 32", o_cnt, o_min_delay, o_max_delay, o_tot_delay);
        else pass_cnt++;
        for (int k = 0; k < 50; k++) tick();
        total_cnt++; if (o_busy !== 1'b1) $display("FAIL wrap_midframe_busy: got %b want 1", o_busy); else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        total_cnt++; if (o_busy !== 1'b0 || o_collisions !== 32'd0 || o_last_src !== 8'h00)
            $display("FAIL abort_state: busy %b coll %0d src %h want 0 0 00", o_busy, o_collisions, o_last_src);
        else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            i_stat_sel = 2'(c); #1;
            total_cnt++;
            if (o_cnt !== 32'h0 || o_min_delay !== 32'hFFFF_FFFF || o_max_delay !== 32'h0 || o_tot_delay !== 64'h0)
                $display("FAIL abort_stats[%0d]: cnt %0d min %h max %0d tot %0d want 0 ffffffff 0 0", c, o_cnt, o_min_delay, o_max_delay, o_tot_delay);
            else pass_cnt++;
        end
        tick();
        total_cnt++; if (o_busy !== 1'b0 || o_done !== 1'b0) $display("FAIL abort_idle: busy %b done %b want 0 0", o_busy, o_done); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0]  src;
        logic [3:0]  pri;
        logic [31:0] data, now;
        int len, offs, early, gap;
        bit ok;
        for (int k = 0; k < 12; k++) begin
            src  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1) << $urandom_range(0, 7);
            pri  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1) << $urandom_range(0, 3);
            data = $urandom;
            now  = data + $urandom_range(0, 5000);
            ok   = ($countones(src) == 1) && ($countones(pri) == 1);
            offer(src, pri, data, now);
            if (ok) begin
                model_accept(src, pri, data, now);
                run_busy(150, len, offs, early);
                m_coll = m_coll + 32'(offs);
                total_cnt++; if (len != HOLD || early != 0 || o_done !== 1'b1)
                    $display("FAIL rand_frame[%0d]: len %0d early %0d done %b want %0d 0 1", k, len, early, o_done, HOLD);
                else pass_cnt++;
            end else begin
                total_cnt++; if (o_err !== 1'b1 || o_busy !== 1'b0)
                    $display("FAIL rand_reject[%0d]: err %b busy %b want 1 0", k, o_err, o_busy);
                else pass_cnt++;
            end
            // A zero gap offers the next frame on the very first idle cycle.
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
        end
        total_cnt++; if (o_collisions !== m_coll || o_last_src !== m_last)
            $display("FAIL rand_coll_src: coll %0d src %h want %0d %h", o_collisions, o_last_src, m_coll, m_last);
        else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            i_stat_sel = 2'(c); #1;
            total_cnt++;
            if (o_cnt !== m_cnt[c] || o_min_delay !== m_min[c] || o_max_delay !== m_max[c] || o_tot_delay !== m_tot[c])
                $display("FAIL rand_stats[%0d]: cnt %0d min %0d max %0d tot %0d want %0d %0d %0d %0d", c,
                         o_cnt, o_min_delay, o_max_delay, o_tot_delay, m_cnt[c], m_min[c], m_max[c], m_tot[c]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_second_frame();
        test_collisions();
        test_malformed();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
